// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// The result is computed at launch, held pending for a fixed latency, then committed.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        Start,
   input  logic [1:0]  Op,
   input  logic        HiWe,
   input  logic        LoWe,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [1:0] {
      OP_MULT  = 2'd0,
      OP_MULTU = 2'd1,
      OP_DIV   = 2'd2,
      OP_DIVU  = 2'd3
   } op_e;

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   op_e                w_op;
   logic signed [63:0] w_prod_s;
   logic        [63:0] w_prod_u;
   logic               w_sdiv;
   logic        [31:0] w_dvd;
   logic        [31:0] w_dvs;
   logic        [31:0] w_dvs_safe;
   logic        [31:0] w_quo;
   logic        [31:0] w_rem;
   logic        [31:0] w_quo_fix;
   logic        [31:0] w_rem_fix;
   logic        [31:0] w_res_hi;
   logic        [31:0] w_res_lo;
   logic               w_res_wr;
   logic [CW-1:0]      w_cnt_init;

   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic [31:0]   r_pend_hi;
   logic [31:0]   r_pend_lo;
   logic          r_pend_wr;
   logic [CW-1:0] r_cnt;
   logic          r_busy;

   assign w_op     = op_e'(Op);
   assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign w_prod_u = {32'd0, A} * {32'd0, B};

   // Signed divide runs on magnitudes so that MIN_INT / -1 wraps cleanly to MIN_INT.
   assign w_sdiv     = (w_op == OP_DIV);
   assign w_dvd      = (w_sdiv && A[31]) ? (~A + 32'd1) : A;
   assign w_dvs      = (w_sdiv && B[31]) ? (~B + 32'd1) : B;
   assign w_dvs_safe = (B == 32'd0) ? 32'd1 : w_dvs;
   assign w_quo      = w_dvd / w_dvs_safe;
   assign w_rem      = w_dvd % w_dvs_safe;
   assign w_quo_fix  = (w_sdiv && (A[31] ^ B[31])) ? (~w_quo + 32'd1) : w_quo;
   assign w_rem_fix  = (w_sdiv && A[31]) ? (~w_rem + 32'd1) : w_rem;

   // NOTE: every output of this block gets a default first, so no latch is inferred.
   always_comb begin
      w_res_hi   = w_prod_s[63:32];
      w_res_lo   = w_prod_s[31:0];
      w_res_wr   = 1'b1;
      w_cnt_init = CW'(MULT_CYCLES);
      case (w_op)
         OP_MULT: ;
         OP_MULTU: begin
            w_res_hi = w_prod_u[63:32];
            w_res_lo = w_prod_u[31:0];
         end
         OP_DIV, OP_DIVU: begin
            w_res_hi   = w_rem_fix;
            w_res_lo   = w_quo_fix;
            w_res_wr   = (B != 32'd0);
            w_cnt_init = CW'(DIV_CYCLES);
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_hi      <= '0;
         r_lo      <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_pend_wr <= 1'b0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
      end else if (r_busy) begin
         // Start, HiWe and LoWe are all ignored while an operation is in flight.
         r_cnt <= r_cnt - CW'(1);
         if (r_cnt == CW'(1)) begin
            r_busy <= 1'b0;
            if (r_pend_wr) begin
               r_hi <= r_pend_hi;
               r_lo <= r_pend_lo;
            end
         end
      end else if (Start) begin
         r_pend_hi <= w_res_hi;
         r_pend_lo <= w_res_lo;
         r_pend_wr <= w_res_wr;
         r_cnt     <= w_cnt_init;
         r_busy    <= 1'b1;
      end else begin
         if (HiWe) r_hi <= A;
         if (LoWe) r_lo <= A;
      end
   end

   assign Busy = r_busy;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: expected HI/LO/latency queued at launch, checked at commit.
module tb_md_unit;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;
   localparam int LIMIT  = 100;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   logic        Clk;
   logic        Reset;
   logic [31:0] A;
   logic [31:0] B;
   logic        Start;
   logic [1:0]  Op;
   logic        HiWe;
   logic        LoWe;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int          n_vec;
   int          n_err;
   exp_t        sb_q[$];
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .Clk(Clk), .Reset(Reset), .A(A), .B(B), .Start(Start), .Op(Op),
      .HiWe(HiWe), .LoWe(LoWe), .Busy(Busy), .HI(HI), .LO(LO)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   // Reference model in 64-bit arithmetic; divide by zero leaves HI/LO as they were.
   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi0, input logic [31:0] lo0);
      exp_t        r;
      longint      sa;
      longint      sb;
      longint      sp;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r.hi = hi0;
      r.lo = lo0;
      r.cycles = (op >= 2'd2) ? DIV_N : MULT_N;
      case (op)
         2'd0: begin
            sp = sa * sb;
            up = sp;
            r.hi = up[63:32];
            r.lo = up[31:0];
         end
         2'd1: begin
            up = {32'd0, a} * {32'd0, b};
            r.hi = up[63:32];
            r.lo = up[31:0];
         end
         2'd2: if (b != 0) begin
            r.lo = 32'(sa / sb);
            r.hi = 32'(sa % sb);
         end
         default: if (b != 0) begin
            r.lo = a / b;
            r.hi = a % b;
         end
      endcase
      return r;
   endfunction

   // Launch one op; optionally re-pulse Start mid-flight, HiWe during Busy, or HiWe with Start.
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit restart, input bit hiwe_busy,
                         input bit hiwe_start);
      exp_t e;
      int   n;
      sb_q.push_back(model(op, a, b, m_hi, m_lo));
      Op    = op;
      A     = a;
      B     = b;
      Start = 1'b1;
      HiWe  = hiwe_start;
      @(negedge Clk);
      Start = 1'b0;
      HiWe  = 1'b0;
      A     = ~a;
      B     = ~b;
      n = 0;
      while (Busy && n < LIMIT) begin
         if (n == 0 || hiwe_busy) begin
            check({tag, "_hold_hi"}, HI, m_hi);
            check({tag, "_hold_lo"}, LO, m_lo);
         end
         Start = restart && (n == 2);
         if (restart && n == 2) begin
            A = 32'd0;
            B = 32'd0;
         end
         HiWe = hiwe_busy && (n == 3);
         if (hiwe_busy && n == 3) A = 32'h1234_5678;
         n++;
         @(negedge Clk);
      end
      Start = 1'b0;
      HiWe  = 1'b0;
      e = sb_q.pop_front();
      check({tag, "_busy_cycles"}, 32'(n), 32'(e.cycles));
      check({tag, "_hi"}, HI, e.hi);
      check({tag, "_lo"}, LO, e.lo);
      m_hi = e.hi;
      m_lo = e.lo;
      @(negedge Clk);
      check({tag, "_idle_after"}, {31'd0, Busy}, 32'd0);
   endtask

   task automatic mt_write(input bit hi, input logic [31:0] val);
      A    = val;
      HiWe = hi;
      LoWe = !hi;
      @(negedge Clk);
      HiWe = 1'b0;
      LoWe = 1'b0;
      if (hi) m_hi = val;
      else    m_lo = val;
      check(hi ? "mthi" : "mtlo", hi ? HI : LO, val);
      check("mt_busy", {31'd0, Busy}, 32'd0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      m_hi  = '0;
      m_lo  = '0;
      Reset = 1'b0;
      A     = '0;
      B     = '0;
      Start = 1'b0;
      Op    = '0;
      HiWe  = 1'b0;
      LoWe  = 1'b0;

      repeat (3) @(negedge Clk);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      Reset = 1'b1;
      @(negedge Clk);
      check("post_rst_hi", HI, 32'd0);
      check("post_rst_lo", LO, 32'd0);
      check("post_rst_busy", {31'd0, Busy}, 32'd0);

      run_op("mult",     2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 0);
      run_op("multu",    2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0, 0, 0);
      run_op("div_neg",  2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 0);
      run_op("divu",     2'd3, 32'h0000_0007, 32'h0000_0002, 0, 0, 0);
      run_op("div_ovf",  2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
      mt_write(1'b1, 32'h0000_0011);
      mt_write(1'b0, 32'h0000_0022);
      run_op("divu_z_hw", 2'd3, 32'h0000_0005, 32'h0000_0000, 0, 0, 1);
      run_op("mult_rst2", 2'd0, 32'h0001_0000, 32'h0001_0003, 1, 1, 0);
      run_op("mult_hw",   2'd0, 32'h0000_0003, 32'hFFFF_FFFC, 0, 0, 1);

      for (int i = 0; i < 6; i++) begin
         logic [1:0]  rop;
         logic [31:0] ra;
         logic [31:0] rb;
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
         run_op($sformatf("rand%0d", i), rop, ra, rb, 0, 0, 0);
      end

      mt_write(1'b0, 32'hDEAD_BEEF);
      mt_write(1'b1, 32'hCAFE_F00D);

      // Reset three cycles into a div: everything clears at once and nothing commits later.
      Op    = 2'd2;
      A     = 32'd100;
      B     = 32'd7;
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      repeat (2) @(negedge Clk);
      check("mid_busy", {31'd0, Busy}, 32'd1);
      Reset = 1'b0;
      #1;
      check("mid_rst_busy", {31'd0, Busy}, 32'd0);
      check("mid_rst_hi", HI, 32'd0);
      check("mid_rst_lo", LO, 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      repeat (DIV_N + 2) @(negedge Clk);
      check("no_commit_busy", {31'd0, Busy}, 32'd0);
      check("no_commit_hi", HI, 32'd0);
      check("no_commit_lo", LO, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
